// File: rtl/f_fetch_unit.sv
// Instruction fetch stage: holds the PC, picks the next PC by redirect priority,
// checks fetch addresses against the instruction-memory window, and counts accepted fetches.
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_en,
  input  logic        intReq,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_isBrJump,
  input  logic        D_brTaken,
  input  logic [31:0] D_brTarget,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic [4:0]  F_exCode,
  output logic        F_isBD,
  output logic [31:0] F_fetchCnt
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_p0;
  logic [31:0] pc_nxt;
  logic [31:0] cnt_p0;
  logic        fetch_acc;
  logic        addr_bad;

  function automatic logic fetch_addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
  endfunction

  // An accepted fetch is one the decode register actually captures.
  assign fetch_acc = F_en && !intReq;

  always_comb begin
    pc_nxt = pc_p0 + 32'd4;
    if (intReq)
      pc_nxt = HANDLER_PC;
    else if (D_eret && F_en)
      pc_nxt = EPC;
    else if (!F_en)
      pc_nxt = pc_p0;
    else if (D_isBrJump && D_brTaken)
      pc_nxt = D_brTarget;
  end

  // Stage p0: PC and fetch counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0  <= RESET_PC;
      cnt_p0 <= 32'd0;
    end else begin
      pc_p0 <= pc_nxt;
      if (fetch_acc)
        cnt_p0 <= cnt_p0 + 32'd1;
    end
  end

  // eret has no delay slot, so the wrong-path word is squashed to a clean nop.
  always_comb begin
    addr_bad = fetch_addr_err(pc_p0);
    F_instr  = i_inst_rdata;
    F_exCode = EXC_NONE;
    F_isBD   = D_isBrJump && !D_eret;
    if (D_eret) begin
      F_instr  = 32'h0;
      F_exCode = EXC_NONE;
    end else if (addr_bad) begin
      F_instr  = 32'h0;
      F_exCode = EXC_ADEL;
    end
  end

  assign i_inst_addr = pc_p0;
  assign F_pc        = pc_p0;
  assign F_fetchCnt  = cnt_p0;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Scoreboard bench for f_fetch_unit: a reference PC/counter model pushes expected
// outputs per cycle, and they are popped and compared on the falling edge.
module tb_f_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
  localparam logic [31:0] MEM_KEY    = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        F_en, intReq, D_eret, D_isBrJump, D_brTaken;
  logic [31:0] EPC, D_brTarget;
  logic [31:0] i_inst_rdata, i_inst_addr, F_pc, F_instr, F_fetchCnt;
  logic [4:0]  F_exCode;
  logic        F_isBD;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] cnt;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  f_fetch_unit #(
    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .IM_LO(IM_LO), .IM_HI(IM_HI)
  ) dut (
    .clk(clk), .reset(reset), .F_en(F_en), .intReq(intReq), .D_eret(D_eret),
    .EPC(EPC), .D_isBrJump(D_isBrJump), .D_brTaken(D_brTaken), .D_brTarget(D_brTarget),
    .i_inst_rdata(i_inst_rdata), .i_inst_addr(i_inst_addr), .F_pc(F_pc),
    .F_instr(F_instr), .F_exCode(F_exCode), .F_isBD(F_isBD), .F_fetchCnt(F_fetchCnt)
  );

  always #5 clk = ~clk;

  assign i_inst_rdata = i_inst_addr ^ MEM_KEY;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
  endfunction

  // One clock: drive inputs, push expectation, compare at negedge, advance model at posedge.
  task automatic cycle(input string tag, input logic en, input logic irq, input logic eret,
                       input logic [31:0] epc, input logic bj, input logic tk,
                       input logic [31:0] tgt);
    exp_t e, o;
    F_en = en; intReq = irq; D_eret = eret; EPC = epc;
    D_isBrJump = bj; D_brTaken = tk; D_brTarget = tgt;
    e.tag = tag;
    e.pc  = m_pc;
    e.cnt = m_cnt;
    e.bd  = bj && !eret;
    if (eret) begin
      e.instr = 32'h0; e.exc = 5'd0;
    end else if (bad_addr(m_pc)) begin
      e.instr = 32'h0; e.exc = 5'd4;
    end else begin
      e.instr = m_pc ^ MEM_KEY; e.exc = 5'd0;
    end
    sbq.push_back(e);
    @(negedge clk);
    o = sbq.pop_front();
    chk({o.tag, ".pc"},    F_pc,       o.pc);
    chk({o.tag, ".addr"},  i_inst_addr, o.pc);
    chk({o.tag, ".instr"}, F_instr,    o.instr);
    chk({o.tag, ".exc"},   {27'd0, F_exCode}, {27'd0, o.exc});
    chk({o.tag, ".bd"},    {31'd0, F_isBD},   {31'd0, o.bd});
    chk({o.tag, ".cnt"},   F_fetchCnt, o.cnt);
    @(posedge clk);
    if (irq)              m_pc = HANDLER_PC;
    else if (eret && en)  m_pc = epc;
    else if (!en)         m_pc = m_pc;
    else if (bj && tk)    m_pc = tgt;
    else                  m_pc = m_pc + 32'd4;
    if (en && !irq) m_cnt = m_cnt + 32'd1;
    #1;
  endtask

  task automatic seq(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic br(input string tag, input logic tk, input logic [31:0] tgt);
    cycle(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, tk, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; F_en = 1'b0; intReq = 1'b1; D_eret = 1'b1; EPC = 32'h3333_0000;
    D_isBrJump = 1'b0; D_brTaken = 1'b0; D_brTarget = 32'h0;
    #2;
    chk("rst_async.pc",  F_pc,       RESET_PC);
    chk("rst_async.cnt", F_fetchCnt, 32'd0);
    @(posedge clk); #1;
    chk("rst_dominates.pc",  F_pc,       RESET_PC);
    chk("rst_dominates.cnt", F_fetchCnt, 32'd0);
    intReq = 1'b0; D_eret = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    m_pc = RESET_PC; m_cnt = 32'd0;

    seq("seq0"); seq("seq1"); seq("seq2");
    seq("seq3");
    br("br_taken", 1'b1, 32'h0000_3400);
    br("br_nottaken", 1'b0, 32'h0000_5000);
    br("br_to_3020", 1'b1, 32'h0000_3020);
    cycle("stall0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle("stall1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3500);
    cycle("irq_stall", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    seq("h0"); seq("h1"); seq("h2"); seq("h3");
    cycle("eret", 1'b1, 1'b0, 1'b1, 32'h0000_3104, 1'b1, 1'b1, 32'h0000_5555);
    cycle("eret_stalled", 1'b0, 1'b0, 1'b1, 32'h0000_3800, 1'b0, 1'b0, 32'h0);
    br("br_misalign", 1'b1, 32'h0000_3002);
    br("br_hi_out", 1'b1, 32'h0000_7000);
    br("br_lo_out", 1'b1, 32'h0000_2FFC);
    br("br_to_top", 1'b1, 32'h0000_6FFC);
    seq("top_edge");
    seq("past_top");
    cycle("irq_eret", 1'b1, 1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0);
    br("br_to_3050", 1'b1, 32'h0000_3050);
    cycle("at_3050", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    #2;
    chk("pre_mid_rst.pc", F_pc, 32'h0000_3050);
    intReq = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst.pc",  F_pc,       RESET_PC);
    chk("mid_rst.cnt", F_fetchCnt, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold.pc", F_pc, RESET_PC);
    intReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    m_pc = RESET_PC; m_cnt = 32'd0;
    seq("post_rst0");
    seq("post_rst1");
    cycle("post_rst2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    if (sbq.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/f_fetch_unit.md
F_FETCH_UNIT -- requirements
Module: f_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180: exception/interrupt entry PC.
REQ-003 Parameter IM_LO / IM_HI, default 32'h0000_3000 / 32'h0000_6FFC: legal fetch address range, inclusive.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-006 F_en  in  1  fetch-stage write enable; 0 = stall, which holds the PC. Same signal as the decode register enable.
REQ-007 intReq  in  1  CP0 interrupt/exception flush request.
REQ-008 D_eret  in  1  the instruction in D is eret.
REQ-009 EPC  in  32  return address from CP0.
REQ-010 D_isBrJump  in  1  the instruction in D is a branch or jump, so the current fetch is its delay slot.
REQ-011 D_brTaken  in  1  the D branch/jump is resolved taken.
REQ-012 D_brTarget  in  32  the D branch/jump target.
REQ-013 i_inst_rdata  in  32  instruction memory read data for i_inst_addr, combinational.
REQ-014 i_inst_addr  out  32  instruction memory address; equals F_pc.
REQ-015 F_pc  out  32  current fetch PC, to the decode register.
REQ-016 F_instr  out  32  fetched instruction, to the decode register.
REQ-017 F_exCode  out  5  fetch exception code; 0 = none, 4 = AdEL.
REQ-018 F_isBD  out  1  the fetched instruction is a branch delay slot.
REQ-019 F_fetchCnt  out  32  count of accepted fetches.

Function
REQ-020 The PC register shall update on each rising clk edge using this priority: intReq -> HANDLER_PC; else D_eret && F_en -> EPC; else !F_en -> hold; else D_isBrJump && D_brTaken -> D_brTarget; else PC+4 (32-bit, wraps modulo 2^32).
REQ-021 intReq shall override the stall: the redirect to HANDLER_PC occurs even when F_en=0.
REQ-022 Address error: when F_pc[1:0]!=0, F_pc<IM_LO, or F_pc>IM_HI, then F_exCode=5'd4 and F_instr=32'h0; otherwise F_exCode=0 and F_instr=i_inst_rdata.
REQ-023 eret has no delay slot: while D_eret=1, F_instr=0, F_exCode=0 and F_isBD=0, so the wrong-path fetch becomes a nop.
REQ-024 F_isBD shall equal D_isBrJump && !D_eret, combinationally; it is valid regardless of whether the branch is taken.
REQ-025 F_pc is driven from the PC register; an erroneous PC is still presented unmodified on F_pc so that CP0 can record it as BadVAddr/EPC.
REQ-026 F_fetchCnt shall increment by 1 on each edge where F_en=1 and intReq=0, and shall wrap from 32'hFFFF_FFFF to 0.
REQ-027 F_fetchCnt shall not increment on intReq edges or on stalled edges.
REQ-028 Fetching from HANDLER_PC shall be subject to the same range check as any other address.
REQ-029 The block contains no other state; the exCode, instr and isBD outputs are combinational functions of the PC and the inputs.

Reset
REQ-030 While reset=1: PC=RESET_PC, F_fetchCnt=0, asynchronously, taking effect without a clock edge.
REQ-031 Reset shall dominate intReq, D_eret and F_en.
REQ-032 After reset deasserts, the first edge with F_en=1 advances the PC to RESET_PC+4.
REQ-033 Reset asserted mid-stall or mid-redirect shall abandon the pending action; no redirect is remembered across reset.

Verification
REQ-034 Reset, then 3 edges with F_en=1 and no branch -> F_pc sequence 0x3000, 0x3004, 0x3008, 0x300C; F_fetchCnt=3.
REQ-035 At F_pc=0x3010: D_isBrJump=1, D_brTaken=1, D_brTarget=0x3400 -> F_isBD=1 this cycle; next F_pc=0x3400 with F_isBD=0.
REQ-036 F_en=0 for 2 edges at 0x3020 -> F_pc stays 0x3020 and F_fetchCnt is unchanged. Then intReq=1 with F_en=0 -> next F_pc=0x4180 and the counter is still unchanged.
REQ-037 D_eret=1, EPC=0x3104, F_en=1 at F_pc=0x4190 -> F_instr=0 and F_isBD=0 this cycle; next F_pc=0x3104.
REQ-038 Branch to 0x3002 -> F_exCode=4, F_instr=0, F_pc=0x3002. Branch to 0x7000 -> F_exCode=4. F_pc=0x6FFC -> F_exCode=0.
REQ-039 Assert reset asynchronously between edges while F_pc=0x3050 -> F_pc=0x3000 and F_fetchCnt=0 before the next clk edge.
